// File: rtl/f_pc_fetch_ctrl.sv
// Fetch-stage PC owner and F/D pipeline register with a BOOT/RUN/HALT controller.
// Optional F/D flush input is enabled by defining FD_FLUSH_EN.
module f_pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
`ifdef FD_FLUSH_EN
  input  logic        flush,
`endif
  input  logic [31:0] npc,
  input  logic [31:0] F_Instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_valid,
  output logic        halted,
  output logic [31:0] bad_pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // One past the last valid byte address; 33 bits so a base near the top cannot wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + ({1'b0, 32'(IM_WORDS)} << 2);

  state_t state;
  state_t state_nxt;

  logic pc_bad;
  logic advance;
  logic enter_halt;
  logic kill_d;

  assign pc_bad = (F_PC[1:0] != 2'b00)
               || (F_PC < IM_BASE)
               || ({1'b0, F_PC} >= IM_END);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its peers; blocking here would create order races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (!stall && pc_bad) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    advance    = 1'b0;
    enter_halt = 1'b0;
    kill_d     = 1'b0;
    if (state == RUN && !stall) begin
      advance    = !pc_bad;
      enter_halt = pc_bad;
`ifdef FD_FLUSH_EN
      kill_d     = !pc_bad && flush;
`endif
    end
  end

  // The bad-PC instruction never reaches D: HALT entry clears D instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_PC      <= RESET_PC;
      D_PC      <= 32'h0;
      D_Instr   <= 32'h0;
      D_valid   <= 1'b0;
      halted    <= 1'b0;
      bad_pc    <= 32'h0;
      fetch_cnt <= 32'h0;
    end else if (advance) begin
      F_PC <= npc;
      D_PC <= F_PC;
      if (kill_d) begin
        D_Instr <= 32'h0;
        D_valid <= 1'b0;
      end else begin
        D_Instr   <= F_Instr;
        D_valid   <= 1'b1;
        fetch_cnt <= fetch_cnt + 32'd1;
      end
    end else if (enter_halt) begin
      halted  <= 1'b1;
      bad_pc  <= F_PC;
      D_Instr <= 32'h0;
      D_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_f_pc_fetch_ctrl.sv
// Directed scoreboard bench for f_pc_fetch_ctrl: expected F/D state is queued per step
// and compared with immediate assertions one cycle later.
module tb_f_pc_fetch_ctrl;

  typedef struct packed {
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_valid;
    logic        halted;
    logic [31:0] bad_pc;
    logic [31:0] fetch_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic [31:0] F_Instr;
  logic [31:0] F_PC, D_PC, D_Instr, bad_pc, fetch_cnt;
  logic        D_valid, halted;
`ifdef FD_FLUSH_EN
  logic        flush;
`endif

  int tests  = 0;
  int failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Combinational instruction memory: distinct word per address.
  function automatic logic [31:0] im(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5A5, pc[15:0]};
  endfunction

  assign F_Instr = im(F_PC);

  f_pc_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
`ifdef FD_FLUSH_EN
    .flush     (flush),
`endif
    .npc       (npc),
    .F_Instr   (F_Instr),
    .F_PC      (F_PC),
    .D_PC      (D_PC),
    .D_Instr   (D_Instr),
    .D_valid   (D_valid),
    .halted    (halted),
    .bad_pc    (bad_pc),
    .fetch_cnt (fetch_cnt)
  );

  function automatic exp_t mk(input logic [31:0] f, input logic [31:0] dp, input logic [31:0] di,
                              input logic dv, input logic h, input logic [31:0] b,
                              input logic [31:0] c);
    exp_t e;
    e.f_pc = f; e.d_pc = dp; e.d_instr = di; e.d_valid = dv;
    e.halted = h; e.bad_pc = b; e.fetch_cnt = c;
    return e;
  endfunction

  localparam exp_t RST = '{f_pc: 32'h3000, d_pc: 32'h0, d_instr: 32'h0, d_valid: 1'b0,
                           halted: 1'b0, bad_pc: 32'h0, fetch_cnt: 32'h0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".F_PC"},      F_PC,             e.f_pc);
    check({tag, ".D_PC"},      D_PC,             e.d_pc);
    check({tag, ".D_Instr"},   D_Instr,          e.d_instr);
    check({tag, ".D_valid"},   {31'h0, D_valid}, {31'h0, e.d_valid});
    check({tag, ".halted"},    {31'h0, halted},  {31'h0, e.halted});
    check({tag, ".bad_pc"},    bad_pc,           e.bad_pc);
    check({tag, ".fetch_cnt"}, fetch_cnt,        e.fetch_cnt);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic step(input string tag, input logic s, input logic [31:0] n, input exp_t e);
    stall = s;
    npc   = n;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Asynchronous reset between edges; checked before any clock edge arrives.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #2;
    sb.push_back(RST);
    compare(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    npc   = 32'h0;
`ifdef FD_FLUSH_EN
    flush = 1'b0;
`endif
    #3;
    sb.push_back(RST);
    compare("reset");
    #3 reset = 1'b0;  // t=6, between edges

    // BOOT ignores stall and npc
    step("boot",  1'b1, 32'h1234, RST);
    step("run1",  1'b0, 32'h3004, mk(32'h3004, 32'h3000, im(32'h3000), 1, 0, 0, 1));
    step("run2",  1'b0, 32'h3008, mk(32'h3008, 32'h3004, im(32'h3004), 1, 0, 0, 2));
    step("run3",  1'b0, 32'h300C, mk(32'h300C, 32'h3008, im(32'h3008), 1, 0, 0, 3));

    // Stall three cycles with npc moving: everything holds
    step("stl1",  1'b1, 32'h4000, mk(32'h300C, 32'h3008, im(32'h3008), 1, 0, 0, 3));
    step("stl2",  1'b1, 32'h4004, mk(32'h300C, 32'h3008, im(32'h3008), 1, 0, 0, 3));
    step("stl3",  1'b1, 32'h4008, mk(32'h300C, 32'h3008, im(32'h3008), 1, 0, 0, 3));
    step("resume",1'b0, 32'h3010, mk(32'h3010, 32'h300C, im(32'h300C), 1, 0, 0, 4));

    // Last valid word accepted, first word past IM halts
    step("jmp",   1'b0, 32'h6FFC, mk(32'h6FFC, 32'h3010, im(32'h3010), 1, 0, 0, 5));
    step("last",  1'b0, 32'h7000, mk(32'h7000, 32'h6FFC, im(32'h6FFC), 1, 0, 0, 6));
    step("badstl",1'b1, 32'h3000, mk(32'h7000, 32'h6FFC, im(32'h6FFC), 1, 0, 0, 6));
    step("halt",  1'b0, 32'h3000, mk(32'h7000, 32'h6FFC, 32'h0, 0, 1, 32'h7000, 6));
    step("hold1", 1'b0, 32'h3020, mk(32'h7000, 32'h6FFC, 32'h0, 0, 1, 32'h7000, 6));
    step("hold2", 1'b1, 32'h3024, mk(32'h7000, 32'h6FFC, 32'h0, 0, 1, 32'h7000, 6));
    async_reset("rst_halt");

    // Misaligned target
    step("boot2", 1'b0, 32'h5555, RST);
    step("mis1",  1'b0, 32'h3002, mk(32'h3002, 32'h3000, im(32'h3000), 1, 0, 0, 1));
    step("mis2",  1'b0, 32'h3006, mk(32'h3002, 32'h3000, 32'h0, 0, 1, 32'h3002, 1));
    step("mis3",  1'b0, 32'h3010, mk(32'h3002, 32'h3000, 32'h0, 0, 1, 32'h3002, 1));
    async_reset("rst_halt2");

    // Below IM_BASE
    step("boot3", 1'b0, 32'h3000, RST);
    step("low1",  1'b0, 32'h2FFC, mk(32'h2FFC, 32'h3000, im(32'h3000), 1, 0, 0, 1));
    step("low2",  1'b0, 32'h3000, mk(32'h2FFC, 32'h3000, 32'h0, 0, 1, 32'h2FFC, 1));
    async_reset("rst_halt3");

    // Reset mid-stall
    step("boot4", 1'b0, 32'h3000, RST);
    step("r4a",   1'b0, 32'h3004, mk(32'h3004, 32'h3000, im(32'h3000), 1, 0, 0, 1));
    step("r4stl", 1'b1, 32'h3100, mk(32'h3004, 32'h3000, im(32'h3000), 1, 0, 0, 1));
    async_reset("rst_stall");

`ifdef FD_FLUSH_EN
    step("boot5", 1'b0, 32'h3000, RST);
    step("f1",    1'b0, 32'h3004, mk(32'h3004, 32'h3000, im(32'h3000), 1, 0, 0, 1));
    flush = 1'b1;
    step("flush", 1'b0, 32'h3008, mk(32'h3008, 32'h3004, 32'h0, 0, 0, 0, 1));
    step("flstl", 1'b1, 32'h3100, mk(32'h3008, 32'h3004, 32'h0, 0, 0, 0, 1));
    flush = 1'b0;
    step("f2",    1'b0, 32'h300C, mk(32'h300C, 32'h3008, im(32'h3008), 1, 0, 0, 2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
